// File: rtl/dec_scan_n_pkg.sv
// Shared types and constants for the one-hot decoder / scanner.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_scan_n_dec.sv
// Combinational N-to-2^N one-hot decoder with output enable.
module dec_n #(
    parameter int N = 3
) (
    input  logic          en,
    input  logic [N-1:0]  in,
    output logic [2**N-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan_n.sv
// One-hot decoder that either holds a handshaken index (DECODE) or
// auto-steps the hot bit across all outputs, DWELL cycles per step (SCAN).
module dec_scan_n
    import dec_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            sel_valid,
    input  logic [N-1:0]    sel,
    output logic            sel_ready,
    output logic [2**N-1:0] o,
    output logic [N-1:0]    idx,
    output logic            wrap,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

    state_t        state_q, state_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;

    // Handshake: sel is taken on a rising edge where sel_valid & sel_ready are
    // both high; sel_ready never depends on sel_valid, so one accept per cycle.
    assign sel_ready = en & (mode == MODE_DECODE) & (state_q != SCAN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else if (mode == MODE_DECODE) begin
            if (state_q == SCAN) begin
                state_d = IDLE;
            end else if (sel_valid && sel_ready) begin
                state_d = HOLD;
                idx_d   = sel;
            end
        end else if (state_q != SCAN) begin
            // Entering SCAN resumes from whatever index is already held.
            state_d = SCAN;
        end else if (cnt_q == CNT_LAST) begin
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == IDX_LAST);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    dec_n #(.N(N)) u_dec (
        .en  (state_q != IDLE),
        .in  (idx_q),
        .out (o)
    );

    assign idx       = idx_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Directed bench for dec_scan_n: N=3/DWELL=4 main instance plus N=2/DWELL=1.
module tb_dec_scan_n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       sel_valid;
    logic [2:0] sel;
    logic       sel_ready;
    logic [7:0] o;
    logic [2:0] idx;
    logic       wrap;
    logic [1:0] state_dbg;

    logic [1:0] sel2;
    logic       sel_ready2;
    logic [3:0] o2;
    logic [1:0] idx2;
    logic       wrap2;
    logic [1:0] state_dbg2;

    int checks = 0;
    int errors = 0;
    logic running = 1'b0;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dec_scan_n #(.N(3), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .sel_ready(sel_ready), .o(o), .idx(idx), .wrap(wrap),
        .state_dbg(state_dbg)
    );

    dec_scan_n #(.N(2), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel2), .sel_ready(sel_ready2), .o(o2), .idx(idx2), .wrap(wrap2),
        .state_dbg(state_dbg2)
    );

    assign sel2 = sel[1:0];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one-hot invariant on both instances every cycle
    always @(negedge clk) begin
        if (running) begin
            check("onehot_o", 32'($countones(o) <= 1), 32'd1);
            check("onehot_o2", 32'($countones(o2) <= 1), 32'd1);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0;
        #1;
        running = 1'b1;

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            en = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            sel_valid = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            tick();
            check("rst_o", o, 8'h00);
            check("rst_idx", idx, 3'd0);
            check("rst_wrap", wrap, 1'b0);
        end
        en = 1'b1; mode = 1'b0; sel_valid = 1'b0;
        #1;
        check("rst_ready", sel_ready, 1'b1);
        rst = 1'b0;

        // 2: decode sel=5, hold, then back-to-back accepts
        sel_valid = 1'b1; sel = 3'd5;
        tick();
        check("dec5_o", o, 8'h20);
        check("dec5_idx", idx, 3'd5);
        sel_valid = 1'b0; sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dec5_hold", o, 8'h20);
        end
        sel_valid = 1'b1; sel = 3'd1;
        tick();
        check("b2b_1", o, 8'h02);
        sel = 3'd7;
        tick();
        check("b2b_7", o, 8'h80);
        sel = 3'd0;
        tick();
        check("dec0_o", o, 8'h01);
        sel_valid = 1'b0;

        // 3: full scan from idx 0, 4 cycles per step, wrap after 32
        mode = 1'b1;
        #1;
        check("scan_ready", sel_ready, 1'b0);
        tick();
        check("scan_k0_o", o, 8'h01);
        check("scan_k0_wrap", wrap, 1'b0);
        for (int k = 1; k < 32; k++) begin
            tick();
            check("scan_o", o, 8'h01 << (k / 4));
            check("scan_wrap", wrap, 1'b0);
        end
        tick();
        check("wrap_o", o, 8'h01);
        check("wrap_pulse", wrap, 1'b1);
        tick();
        check("wrap_clear", wrap, 1'b0);
        check("wrap_o2", o, 8'h01);

        // 5: en drop mid-scan at idx 6, resume with full dwell, rst mid-scan
        for (int i = 0; i < 23; i++) tick();
        check("at6_idx", idx, 3'd6);
        check("at6_o", o, 8'h40);
        tick();
        en = 1'b0;
        tick();
        check("en0_o", o, 8'h00);
        check("en0_idx", idx, 3'd6);
        check("en0_wrap", wrap, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("resume_o", o, 8'h40);
        end
        tick();
        check("resume_next", o, 8'h80);
        rst = 1'b1;
        tick();
        check("rstmid_o", o, 8'h00);
        check("rstmid_idx", idx, 3'd0);
        check("rstmid_state", state_dbg, 2'd0);
        rst = 1'b0;
        tick();
        check("rescan_o", o, 8'h01);

        // 6: sel ignored in SCAN, scan->decode at idx 3, then accept sel=2
        for (int i = 0; i < 12; i++) tick();
        check("at3_o", o, 8'h08);
        sel_valid = 1'b1; sel = 3'd2;
        #1;
        check("scan_sel_ready", sel_ready, 1'b0);
        tick();
        check("scan_sel_ign", idx, 3'd3);
        sel_valid = 1'b0;
        mode = 1'b0;
        tick();
        check("s2d_o", o, 8'h00);
        check("s2d_idx", idx, 3'd3);
        check("s2d_ready", sel_ready, 1'b1);
        sel_valid = 1'b1; sel = 3'd2;
        tick();
        check("s2d_dec2", o, 8'h04);
        sel_valid = 1'b0;

        // 4: N=2, DWELL=1 instance steps every cycle, wrap every 4th
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("d1_o2", o2, 4'h1 << (k % 4));
            check("d1_wrap2", wrap2, 1'((k % 4 == 0) && (k > 0)));
        end

        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
